matrix_multiplier_3x3: RTL and testbench
========================================

# matrix_multiplier_3x3

Computes C = A × B for two 3×3 matrices of 8-bit minifloat values using a 3×3 systolic array of multiply-accumulate processing elements (PEs). It is a standalone compute block. A level `start` launches one multiplication on operands captured from parallel input ports. The nine results are presented on parallel output ports with a sticky `done` flag.

## Interface
- No parameters. The number format and the 3×3 size are fixed.
- `clk`  in  1  Single clock; all state changes on the rising edge.
- `reset`  in  1  Asynchronous, active-low reset; `reset`=0 clears all state immediately.
- `start`  in  1  Level request; sampled only in IDLE.
- `a00`..`a22`  in  8 each  Matrix A elements; `aRC` is row R, column C.
- `b00`..`b22`  in  8 each  Matrix B elements; `bRC` is row R, column C.
- `M0_out`..`M8_out`  out  8 each  Matrix C in row-major order: `M(3i+j)_out` = C[i][j].
- `done`  out  1  High while results are valid for the current request.

## Operation
- **Number format (1-3-4):**
  - bit7 is the sign, bits6:4 are the exponent E (bias 3), bits3:0 are the fraction F.
  - Value = (−1)^s × 1.F × 2^(E−3) for E ≥ 1.
  - Any input with E=0 is zero, regardless of F or s. No denormals, no infinities, no NaN.
  - Examples: 0x30=1.0, 0x20=0.5, 0xB8=−1.5, 0x90=−0.25, 0x44=2.5, 0x42=2.25, 0x34=1.25.
  - Max magnitude is 0x7F (31.0). Min normal is 0x10 (0.25).
- **Arithmetic per operation (multiply, add):**
  - Compute the exact real result, then truncate toward zero to 4 fraction bits.
  - If the truncated magnitude is below 0.25, flush to +0 (0x00).
  - If the magnitude exceeds 31, saturate to ±max (0x7F/0xFF).
  - An exact zero result is always 0x00.
  - The product is rounded before it is added.
- **Accumulation order (fixed):** each PE(i,j) computes acc = ((0 + a[i][0]·b[0][j]) + a[i][1]·b[1][j]) + a[i][2]·b[2][j]. Each step is rounded.
- **Systolic dataflow:**
  - A rows enter from the left and are skewed by row index. B columns enter from the top and are skewed by column index.
  - Each PE passes its a operand right and its b operand down through registers.
  - PE(i,j) consumes term k at compute step i+j+k, for steps 0..6.
- **FSM states:** IDLE, COMPUTE, DONE.
  - IDLE → COMPUTE when `start`=1. On that edge: capture all 18 operand inputs, clear the accumulators and the step counter. Operand inputs are ignored after capture.
  - COMPUTE executes one step per edge. After step 6 it writes the accumulators to `M0_out`..`M8_out`, sets `done`=1 and goes to DONE.
  - DONE stays in DONE while `start`=1, so a held `start` never relaunches a computation.
  - DONE → IDLE when `start`=0. On that edge `done` goes to 0 and the outputs keep their values.
- `start` deassertion during COMPUTE is ignored; the computation completes.

## Timing
- **Reset values:** `M0_out`..`M8_out`=0x00, `done`=0, state IDLE, accumulators and pipeline registers 0.
- **Latency:**
  - Edge E0 samples `start`=1 in IDLE and captures the operands.
  - Edges E1..E7 perform steps 0..6.
  - Outputs and `done`=1 are visible after E7, 7 cycles after capture.
- Outputs change only at the E7 update edge and on reset. They never show partial sums.
- **Reset mid-COMPUTE:** abort immediately, with all outputs cleared per the reset values. A new request requires `start`=1 after `reset` returns high.
- **Back-to-back requests:** each request needs a `start` low phase of at least one cycle in DONE before it can launch.

## Test plan
- **Reference vector:**
  - Inputs: A rows {0x20,0x20,0x30},{0x20,0x30,0xB8},{0x90,0x20,0x30}; B rows {0x30,0x44,0x44},{0x30,0x30,0x30},{0x30,0x20,0x20}; `start` held high.
  - Expected: M0..M8 = 0x40,0x42,0x42,0x00,0x38,0x38,0x34,0x20,0x20.
  - `done` rises exactly 7 cycles after the capture edge and stays high. C[2][1] depends on −0.125 flushing to zero.
- **Identity:** A arbitrary with all normal values, B = diag(0x30) with zeros elsewhere → M equals A row-major.
- **Overflow:** A all 0x60 (8.0), B all 0x60 → every M = 0x7F. With A all 0xE0 instead → every M = 0xFF.
- **Underflow:** A all 0x10, B all 0x10 → every M = 0x00. A all 0x20, B all 0x20 → every M = 0x28 (0.75).
- **Reset mid-compute:** drive `reset`=0 three cycles after capture → outputs read 0x00 and `done`=0 at once. A later `start` completes the full computation normally.
- **Handshake:**
  - Hold `start` after `done` → no recomputation, even if operand inputs change.
  - Drop `start` → `done`=0 and outputs are unchanged.
  - Raise `start` with new operands → new results after 7 cycles.

Source files
------------

// File: rtl/matrix_multiplier_3x3.sv
// matrix_multiplier_3x3: C = A x B for 3x3 minifloat (1-3-4) matrices on a 3x3 systolic MAC array.
// Every multiply and add truncates toward zero, flushes below 0.25 to +0 and saturates above 31.
module matrix_multiplier_3x3 (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] a00, a01, a02, a10, a11, a12, a20, a21, a22,
    input  logic [7:0] b00, b01, b02, b10, b11, b12, b20, b21, b22,
    output logic [7:0] M0_out, M1_out, M2_out, M3_out, M4_out, M5_out, M6_out, M7_out, M8_out,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
    state_t     state_q;
    logic [2:0] step_q;
    logic       done_q;
    logic [7:0] a_q [3][3], b_q [3][3];
    logic [7:0] ap_q [3][3], bp_q [3][3];
    logic [7:0] acc_q [3][3], acc_d [3][3];
    logic [7:0] a_in [3][3], b_in [3][3];
    logic [7:0] a_cap [3][3], b_cap [3][3];
    logic [7:0] m_q [9];
    logic [2:0] k;

    // Magnitudes are handled as unsigned fixed point with 12 fraction bits.
    function automatic logic [7:0] to_mf(input logic s, input logic [23:0] mag);
        int p;
        logic [3:0] f;
        p = 0;
        for (int n = 0; n < 24; n++) if (mag[n]) p = n;
        f = 4'(mag >> (p - 4));
        return (mag > 24'd126976) ? {s, 7'h7F} : (p < 10 ? 8'h00 : {s, 3'(p - 9), f});
    endfunction

    function automatic logic [23:0] mag_of(input logic [7:0] x);
        return (x[6:4] == 3'd0) ? 24'h0 : 24'({1'b1, x[3:0]}) << (x[6:4] + 5);
    endfunction

    function automatic logic [7:0] mf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [23:0] p;
        p = 24'({1'b1, a[3:0]}) * 24'({1'b1, b[3:0]});
        return (a[6:4] == 3'd0 || b[6:4] == 3'd0) ? 8'h00 : to_mf(a[7] ^ b[7], p << (a[6:4] + b[6:4] - 2));
    endfunction

    function automatic logic [7:0] mf_add(input logic [7:0] a, input logic [7:0] b);
        logic signed [24:0] va, vb, sum;
        va = a[7] ? -$signed({1'b0, mag_of(a)}) : $signed({1'b0, mag_of(a)});
        vb = b[7] ? -$signed({1'b0, mag_of(b)}) : $signed({1'b0, mag_of(b)});
        sum = va + vb;
        return to_mf(sum[24], 24'(sum[24] ? -sum : sum));
    endfunction

    assign a_cap = '{'{a00, a01, a02}, '{a10, a11, a12}, '{a20, a21, a22}};
    assign b_cap = '{'{b00, b01, b02}, '{b10, b11, b12}, '{b20, b21, b22}};

    // Row i of A and column i of B enter i steps late; out-of-window slots feed zero, a no-op term.
    always_comb begin
        k = 3'd0;
        for (int i = 0; i < 3; i++) begin
            k = step_q - 3'(i);
            a_in[i][0] = (step_q >= 3'(i) && k <= 3'd2) ? a_q[i][k[1:0]] : 8'h00;
            b_in[0][i] = (step_q >= 3'(i) && k <= 3'd2) ? b_q[k[1:0]][i] : 8'h00;
            for (int j = 1; j < 3; j++) begin
                a_in[i][j] = ap_q[i][j-1];
                b_in[j][i] = bp_q[j-1][i];
            end
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                acc_d[i][j] = mf_add(acc_q[i][j], mf_mul(a_in[i][j], b_in[i][j]));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            step_q  <= 3'd0;
            done_q  <= 1'b0;
            a_q     <= '{default: 8'h00};
            b_q     <= '{default: 8'h00};
            ap_q    <= '{default: 8'h00};
            bp_q    <= '{default: 8'h00};
            acc_q   <= '{default: 8'h00};
            m_q     <= '{default: 8'h00};
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q <= COMPUTE;
                    step_q  <= 3'd0;
                    a_q     <= a_cap;
                    b_q     <= b_cap;
                    ap_q    <= '{default: 8'h00};
                    bp_q    <= '{default: 8'h00};
                    acc_q   <= '{default: 8'h00};
                end
                COMPUTE: begin
                    acc_q  <= acc_d;
                    ap_q   <= a_in;
                    bp_q   <= b_in;
                    step_q <= step_q + 3'd1;
                    if (step_q == 3'd6) begin
                        for (int i = 0; i < 3; i++)
                            for (int j = 0; j < 3; j++)
                                m_q[3*i+j] <= acc_d[i][j];
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: if (!start) begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign {M0_out, M1_out, M2_out, M3_out, M4_out, M5_out, M6_out, M7_out, M8_out} =
           {m_q[0], m_q[1], m_q[2], m_q[3], m_q[4], m_q[5], m_q[6], m_q[7], m_q[8]};
    assign done = done_q;
endmodule

// File: tb/tb_matrix_multiplier_3x3.sv
// tb_matrix_multiplier_3x3: directed and random checks of the 3x3 minifloat matrix multiplier
// against a real-arithmetic reference model.
module tb_matrix_multiplier_3x3;
    logic       clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [7:0] av [3][3], bv [3][3], mo [9];
    logic       done;
    logic [7:0] expm [9], oldm [9];
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    matrix_multiplier_3x3 dut (
        .clk(clk), .reset(reset), .start(start),
        .a00(av[0][0]), .a01(av[0][1]), .a02(av[0][2]),
        .a10(av[1][0]), .a11(av[1][1]), .a12(av[1][2]),
        .a20(av[2][0]), .a21(av[2][1]), .a22(av[2][2]),
        .b00(bv[0][0]), .b01(bv[0][1]), .b02(bv[0][2]),
        .b10(bv[1][0]), .b11(bv[1][1]), .b12(bv[1][2]),
        .b20(bv[2][0]), .b21(bv[2][1]), .b22(bv[2][2]),
        .M0_out(mo[0]), .M1_out(mo[1]), .M2_out(mo[2]),
        .M3_out(mo[3]), .M4_out(mo[4]), .M5_out(mo[5]),
        .M6_out(mo[6]), .M7_out(mo[7]), .M8_out(mo[8]),
        .done(done)
    );

    function automatic real dec(input logic [7:0] x);
        real sc;
        sc = 1.0 / 64.0;
        if (x[6:4] == 3'd0) return 0.0;
        for (int e = 1; e < int'(x[6:4]); e++) sc = sc * 2.0;
        return (x[7] ? -1.0 : 1.0) * real'(16 + int'(x[3:0])) * sc;
    endfunction

    function automatic logic [7:0] enc(input real r);
        real m, sc;
        int e;
        logic s;
        s = (r < 0.0);
        m = s ? -r : r;
        if (m < 0.25) return 8'h00;
        if (m > 31.0) return {s, 7'h7F};
        sc = 16.0;
        e = 7;
        while (m < sc) begin
            sc = sc / 2.0;
            e--;
        end
        return {s, 3'(e), 4'($rtoi((m / sc - 1.0) * 16.0))};
    endfunction

    task automatic model();
        logic [7:0] acc;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                acc = 8'h00;
                for (int k = 0; k < 3; k++)
                    acc = enc(dec(acc) + dec(enc(dec(av[i][k]) * dec(bv[k][j]))));
                expm[3*i+j] = acc;
            end
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_outs(input string tag);
        for (int i = 0; i < 9; i++) chk($sformatf("%s M%0d", tag, i), mo[i], expm[i]);
    endtask

    task automatic launch(input string tag);
        int n;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 20);
        chk({tag, " latency"}, 8'(n), 8'd7);
        chk_outs(tag);
    endtask

    task automatic release_start(input string tag);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, " done low"}, {7'd0, done}, 8'd0);
        chk_outs({tag, " kept"});
    endtask

    task automatic fill(input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                av[i][j] = a;
                bv[i][j] = b;
            end
    endtask

    initial begin
        fill(8'h00, 8'h00);
        #12;
        chk("reset done", {7'd0, done}, 8'd0);
        for (int i = 0; i < 9; i++) expm[i] = 8'h00;
        chk_outs("reset");
        @(negedge clk);
        reset = 1'b1;

        av = '{'{8'h20, 8'h20, 8'h30}, '{8'h20, 8'h30, 8'hB8}, '{8'h90, 8'h20, 8'h30}};
        bv = '{'{8'h30, 8'h44, 8'h44}, '{8'h30, 8'h30, 8'h30}, '{8'h30, 8'h20, 8'h20}};
        expm = '{8'h40, 8'h42, 8'h42, 8'h00, 8'h38, 8'h38, 8'h34, 8'h20, 8'h20};
        launch("ref");
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                av[i][j] = 8'($urandom);
                bv[i][j] = 8'($urandom);
            end
        repeat (10) @(posedge clk);
        #1;
        chk("hold done", {7'd0, done}, 8'd1);
        chk_outs("hold");
        release_start("ref");

        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                av[i][j] = {1'($urandom), 3'($urandom_range(1, 7)), 4'($urandom)};
                bv[i][j] = (i == j) ? 8'h30 : 8'h00;
                expm[3*i+j] = av[i][j];
            end
        launch("ident");
        release_start("ident");

        fill(8'h60, 8'h60);
        for (int i = 0; i < 9; i++) expm[i] = 8'h7F;
        launch("ovf_pos");
        release_start("ovf_pos");
        fill(8'hE0, 8'h60);
        for (int i = 0; i < 9; i++) expm[i] = 8'hFF;
        launch("ovf_neg");
        release_start("ovf_neg");
        fill(8'h10, 8'h10);
        for (int i = 0; i < 9; i++) expm[i] = 8'h00;
        launch("unf_flush");
        release_start("unf_flush");
        fill(8'h20, 8'h20);
        for (int i = 0; i < 9; i++) expm[i] = 8'h28;
        launch("unf_sum");
        release_start("unf_sum");

        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) begin
                    av[i][j] = 8'($urandom);
                    bv[i][j] = 8'($urandom);
                end
            model();
            launch($sformatf("rand%0d", t));
            release_start($sformatf("rand%0d", t));
        end

        oldm = expm;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                av[i][j] = {1'($urandom), 3'($urandom_range(2, 6)), 4'($urandom)};
                bv[i][j] = {1'($urandom), 3'($urandom_range(2, 6)), 4'($urandom)};
            end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) chk($sformatf("no partial M%0d", i), mo[i], oldm[i]);
        #1;
        reset = 1'b0;
        #1;
        chk("midreset done", {7'd0, done}, 8'd0);
        for (int i = 0; i < 9; i++) expm[i] = 8'h00;
        chk_outs("midreset");
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        model();
        launch("after_reset");
        release_start("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
